// File: rtl/rijndael_roundkey_store.sv
// Purpose  : captures the NR+1 round keys produced by an external Rijndael key schedule
//            and plays them back as a valid/ready stream, in forward or reverse order.
// Latency  : capture takes 1 clear cycle plus NR+1 fill cycles. Playback reads the store
//            combinationally, so a beat is offered in the cycle after play_i is taken.
// Backpressure: roundkey_o holds while rk_valid_o is high and rk_ready_i is low.
//            The index steps only on a handshake.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge) and asynchronous active-low reset
//   start_i            pulse that starts key capture (accepted in IDLE or READY)
//   ks_clear_no        registered active-low clear sent to the upstream key schedule
//   ks_enable_o        advance strobe sent to the key schedule (high only while filling)
//   ks_roundkey_i      current round key from the key schedule
//   play_i, decrypt_i  pulse that starts playback, and the order (1 = reverse) sampled with it
//   rk_valid_o, rk_ready_i, roundkey_o   the playback stream
//   loaded_o, busy_o   a full key set is stored / the block is in CLR, FILL or PLAY
//   clear_i            zeroize request. It is honoured only when RIJNDAEL_KEYSTORE_ZEROIZE_EN
//                      is defined; otherwise the port is present and ignored.

module rijndael_roundkey_store #(
  parameter int NB = 4,  // state width in 32-bit words (4, 6 or 8)
  parameter int NK = 4   // key length in 32-bit words (4, 6 or 8)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              ks_clear_no,
  output logic              ks_enable_o,
  input  logic [32*NB-1:0]  ks_roundkey_i,
  input  logic              play_i,
  input  logic              decrypt_i,
  output logic              rk_valid_o,
  input  logic              rk_ready_i,
  output logic [32*NB-1:0]  roundkey_o,
  output logic              loaded_o,
  output logic              busy_o,
  input  logic              clear_i
);

  // The number of rounds follows the larger of the block and key sizes.
  // One extra key is needed for the initial AddRoundKey.
  localparam int NR   = ((NB > NK) ? NB : NK) + 6;
  localparam int IDXW = $clog2(NR + 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FILL  = 3'd2,
    READY = 3'd3,
    PLAY  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              rev_q, rev_d;      // latched playback direction (1 = reverse)
  logic              loaded_q, loaded_d;
  logic              ks_clear_nq;
  logic              mem_we;
  logic              zeroize;

  logic [32*NB-1:0]  mem [0:NR];

  // Zeroize request. When the feature is compiled out, it is tied off so that every
  // path keyed on it optimises away.
`ifdef RIJNDAEL_KEYSTORE_ZEROIZE_EN
  assign zeroize = clear_i;
`else
  logic unused_clear;
  assign zeroize      = 1'b0;
  assign unused_clear = clear_i;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rev_d    = rev_q;
    loaded_d = loaded_q;
    mem_we   = 1'b0;

    if (zeroize) begin
      // Zeroize overrides every other request and every state.
      state_d  = IDLE;
      idx_d    = '0;
      loaded_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // play_i has no meaning without a stored key set.
          if (start_i) begin
            state_d  = CLR;
            loaded_d = 1'b0;
          end
        end

        CLR: begin
          // The key schedule sees ks_clear_no low for this single cycle.
          state_d = FILL;
          idx_d   = '0;
        end

        FILL: begin
          mem_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d  = READY;
            loaded_d = 1'b1;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end

        READY: begin
          // A recapture takes precedence over playback when both are requested.
          if (start_i) begin
            state_d  = CLR;
            loaded_d = 1'b0;
          end else if (play_i) begin
            state_d = PLAY;
            rev_d   = decrypt_i;
            idx_d   = decrypt_i ? IDX_LAST : '0;
          end
        end

        PLAY: begin
          if (rk_ready_i) begin
            if (rev_q) begin
              if (idx_q == '0) begin
                state_d = READY;
              end else begin
                idx_d = idx_q - 1'b1;
              end
            end else begin
              if (idx_q == IDX_LAST) begin
                state_d = READY;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rev_q       <= 1'b0;
      loaded_q    <= 1'b0;
      ks_clear_nq <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rev_q       <= rev_d;
      loaded_q    <= loaded_d;
      // This is registered from the next state so that the clear sits on a flop output.
      // The output therefore cannot glitch, and it is low exactly while in CLR.
      ks_clear_nq <= (state_d != CLR);
    end
  end

  // ---------------------------------------------------------------------------
  // Round-key store
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= NR; i++) begin
        mem[i] <= '0;
      end
    end else if (zeroize) begin
      for (int i = 0; i <= NR; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[idx_q] <= ks_roundkey_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ks_clear_no = ks_clear_nq;
  assign ks_enable_o = (state_q == FILL);
  assign rk_valid_o  = (state_q == PLAY);
  assign busy_o      = (state_q == CLR) || (state_q == FILL) || (state_q == PLAY);
  assign loaded_o    = loaded_q;

  // Zero-latency read from the registered index. The key is forced to zero outside
  // PLAY so that stored material is not exposed on the port.
  assign roundkey_o  = rk_valid_o ? mem[idx_q] : '0;

endmodule

// File: tb/tb_rijndael_roundkey_store.sv
// Bench for rijndael_roundkey_store. Instance A (NB=NK=4) is fed the FIPS-197 AES-128
// expansion of 2b7e151628aed2a6abf7158809cf4f3c. Instance B (NB=4, NK=8) is fed a
// synthetic 15-key sequence. Expected playback keys are queued when play_i is driven.

module tb_rijndael_roundkey_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         a_start, a_ks_clear_n, a_ks_en, a_play, a_dec, a_vld, a_rdy;
  logic         a_loaded, a_busy, a_clear;
  logic [127:0] a_ks_rk, a_rk;

  logic         b_start, b_ks_clear_n, b_ks_en, b_play, b_dec, b_vld, b_rdy;
  logic         b_loaded, b_busy, b_clear;
  logic [127:0] b_ks_rk, b_rk;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];

  logic [127:0] aes_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  rijndael_roundkey_store #(.NB(4), .NK(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start),
    .ks_clear_no(a_ks_clear_n), .ks_enable_o(a_ks_en), .ks_roundkey_i(a_ks_rk),
    .play_i(a_play), .decrypt_i(a_dec), .rk_valid_o(a_vld), .rk_ready_i(a_rdy),
    .roundkey_o(a_rk), .loaded_o(a_loaded), .busy_o(a_busy), .clear_i(a_clear)
  );

  rijndael_roundkey_store #(.NB(4), .NK(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start),
    .ks_clear_no(b_ks_clear_n), .ks_enable_o(b_ks_en), .ks_roundkey_i(b_ks_rk),
    .play_i(b_play), .decrypt_i(b_dec), .rk_valid_o(b_vld), .rk_ready_i(b_rdy),
    .roundkey_o(b_rk), .loaded_o(b_loaded), .busy_o(b_busy), .clear_i(b_clear)
  );

  // Key-schedule models. Each one restarts on clear and advances on enable.
  int a_ks_idx = 0;
  int b_ks_idx = 0;

  function automatic logic [127:0] b_key(input int k);
    return {32'h1111_0000 + 32'(k), 32'h2222_0000 + 32'(k),
            32'h3333_0000 + 32'(k), 32'h4444_0000 + 32'(k)};
  endfunction

  always @(posedge clk) begin
    if (!a_ks_clear_n) a_ks_idx <= 0;
    else if (a_ks_en)  a_ks_idx <= a_ks_idx + 1;
    if (!b_ks_clear_n) b_ks_idx <= 0;
    else if (b_ks_en)  b_ks_idx <= b_ks_idx + 1;
  end

  always_comb begin
    a_ks_rk = '0;
    if (a_ks_idx >= 0 && a_ks_idx <= 10) a_ks_rk = aes_rk[a_ks_idx];
    b_ks_rk = b_key(b_ks_idx);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start_i on A, then count clear and enable cycles until loaded_o rises.
  task automatic a_fill(input string tag);
    int clr_n;
    int en_n;
    clr_n = 0;
    en_n  = 0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!a_ks_clear_n) clr_n++;
      if (a_ks_en) en_n++;
      if (a_loaded) break;
      step();
    end
    check({tag, " clear cycles"}, 128'(clr_n), 128'd1);
    check({tag, " enable cycles"}, 128'(en_n), 128'd11);
    check({tag, " loaded"}, {126'd0, a_loaded, a_busy}, 128'b10);
  endtask

  // Play back all 11 keys on A. When rnd is set, the ready signal is randomised.
  task automatic a_playback(input logic dec, input bit rnd, input string tag);
    int beats;
    bit stalled;
    logic [127:0] held;
    logic [127:0] e;
    exp_q.delete();
    for (int k = 0; k <= 10; k++) exp_q.push_back(dec ? aes_rk[10 - k] : aes_rk[k]);
    a_play = 1'b1;
    a_dec  = dec;
    step();
    a_play  = 1'b0;
    beats   = 0;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 300; c++) begin
      if (!a_vld) break;
      if (stalled) check({tag, " hold"}, a_rk, held);
      a_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_rdy) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check({tag, " beat"}, a_rk, e);
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = a_rk;
      end
      step();
    end
    a_rdy = 1'b0;
    check({tag, " beats"}, 128'(beats), 128'd11);
    check({tag, " ready after"}, {125'd0, a_vld, a_busy, a_loaded}, 128'b001);
  endtask

  initial begin
    int b_en;
    int b_beats;
    logic [127:0] e;

    rst_n = 1'b0;
    {a_start, a_play, a_dec, a_rdy, a_clear} = '0;
    {b_start, b_play, b_dec, b_rdy, b_clear} = '0;
    step();
    check("reset ctl", {123'd0, a_ks_clear_n, a_ks_en, a_loaded, a_busy, a_vld}, 128'b10000);
    check("reset key", a_rk, 128'd0);
    rst_n = 1'b1;
    step();

    // play_i in IDLE must be ignored.
    a_play = 1'b1;
    step();
    a_play = 1'b0;
    check("idle play", {125'd0, a_vld, a_busy, a_loaded}, 128'b000);

    a_fill("fill1");
    a_playback(1'b0, 1'b0, "fwd");
    a_playback(1'b1, 1'b1, "rev");
    a_playback(1'b0, 1'b1, "fwd2");

    // When start_i and play_i arrive together in READY, start_i wins.
    a_start = 1'b1;
    a_play  = 1'b1;
    step();
    a_start = 1'b0;
    a_play  = 1'b0;
    check("start wins", {125'd0, a_ks_clear_n, a_vld, a_busy}, 128'b001);
    for (int c = 0; c < 40; c++) begin
      if (a_loaded) break;
      step();
    end
    check("refill loaded", {127'd0, a_loaded}, 128'd1);
    a_playback(1'b0, 1'b0, "fwd3");

    // Instance B (NR = 14). play_i is pulsed during FILL and must be ignored.
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_en = 0;
    for (int c = 0; c < 60; c++) begin
      if (b_ks_en) b_en++;
      b_play = (c == 3);
      if (b_loaded) break;
      step();
    end
    b_play = 1'b0;
    check("b enable cycles", 128'(b_en), 128'd15);
    step();
    check("b fill play ignored", {126'd0, b_vld, b_loaded}, 128'b01);
    exp_q.delete();
    for (int k = 0; k <= 14; k++) exp_q.push_back(b_key(k));
    b_play = 1'b1;
    b_dec  = 1'b0;
    b_rdy  = 1'b1;
    step();
    b_play  = 1'b0;
    b_beats = 0;
    for (int c = 0; c < 60; c++) begin
      if (!b_vld) break;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check("b beat", b_rk, e);
      b_beats++;
      step();
    end
    b_rdy = 1'b0;
    check("b beats", 128'(b_beats), 128'd15);

    // Assert reset during playback on A, at beat 5.
    a_play = 1'b1;
    a_dec  = 1'b0;
    a_rdy  = 1'b1;
    step();
    a_play = 1'b0;
    repeat (5) step();
    check("beat5 before reset", {127'd0, a_vld}, 128'd1);
    check("beat5 key", a_rk, aes_rk[5]);
    #1 rst_n = 1'b0;
    #1;
    check("midplay reset ctl", {123'd0, a_ks_clear_n, a_ks_en, a_loaded, a_busy, a_vld}, 128'b10000);
    check("midplay reset key", a_rk, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_rdy = 1'b0;
    step();
    a_play = 1'b1;
    step();
    a_play = 1'b0;
    check("post reset play", {125'd0, a_vld, a_busy, a_loaded}, 128'b000);

    // Zeroize request while A is in READY.
    a_fill("fill4");
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
`ifdef RIJNDAEL_KEYSTORE_ZEROIZE_EN
    check("zeroize", {126'd0, a_loaded, a_busy}, 128'b00);
    a_play = 1'b1;
    step();
    a_play = 1'b0;
    check("zeroize play ignored", {127'd0, a_vld}, 128'd0);
    a_fill("fill5");
    a_playback(1'b0, 1'b0, "post zeroize");
`else
    check("clear ignored", {126'd0, a_loaded, a_busy}, 128'b10);
    a_playback(1'b0, 1'b0, "after clear");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
